vram_arbiter: RTL
=================

# vram_arbiter

Shares one single-port synchronous video RAM (8-bit data, 1-cycle read latency) between the scanout engine and the CPU bus. Scanout has absolute priority and sees the RAM with unchanged timing. CPU accesses use a req/ack handshake and are slotted into cycles where scanout is idle: text-mode idle character phases, odd pixel phases in 320x200x256 mode, and blanking. A one-entry posted write buffer and read-after-write forwarding hide most CPU latency. A stall monitor records the worst-case CPU wait.

## Interface
Parameters:
- AW, 18: RAM address width (256 KB).
- SW, 16: stall counter width.

Ports (clock and reset first):
- clock_25  in  1  system/pixel clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- vid_req  in  1  scanout wants the RAM this cycle.
- vid_addr  in  AW  scanout address.
- vid_rdata  out  8  scanout read data; valid the cycle after vid_req.
- cpu_req  in  1  CPU request; held with stable fields until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data; valid when cpu_ack is high, held until the next read ack.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, 1-cycle latency.
- stall_clr  in  1  synchronous clear of stall_max.
- stall_max  out  SW  longest CPU wait seen, in cycles, saturating.

## Operation
- Slot mux is combinational, so scanout adds 0 cycles of latency:
  - If vid_req: mem_addr=vid_addr, mem_we=0.
  - Else if the write buffer (WB) is full: drive the WB address and data with mem_we=1, and WB empties at the clock edge.
  - Else if state is RD_WAIT: drive the read address with mem_we=0, and go to RD_DATA.
  - Else: mem_we=0, mem_addr holds its last value.
- vid_rdata = mem_rdata, passed through.
- CPU FSM states are IDLE, RD_WAIT, RD_DATA, ACK.
  - IDLE, cpu_req with cpu_we=1 and WB empty: load WB, go to ACK.
  - IDLE, cpu_req with cpu_we=1 and WB full: stay in IDLE until WB drains.
  - IDLE, cpu_req with cpu_we=0 and WB full on the same address: forward the WB data to cpu_rdata, go to ACK. No RAM access.
  - IDLE, cpu_req with cpu_we=0 otherwise: latch the address, go to RD_WAIT. If WB is full on a different address, the write drains first; the slot priority above guarantees this ordering.
  - RD_WAIT: wait for a free slot with WB empty, then issue the read and go to RD_DATA.
  - RD_DATA: capture mem_rdata into cpu_rdata, go to ACK.
  - ACK: cpu_ack=1 for exactly one cycle, then IDLE. cpu_req is ignored in ACK, so the requester has one cycle to drop or change it.
- WB write data is captured in the accept cycle. A read in RD_WAIT cannot be overtaken by a later write, because requests are accepted one at a time.
- Stall monitor:
  - wait_cnt increments every cycle that cpu_req=1 and the FSM is not in ACK.
  - wait_cnt clears in ACK.
  - stall_max = max(stall_max, wait_cnt), saturating at 2^SW-1.
  - stall_clr has priority and zeroes stall_max. If stall_clr and an update coincide, the result is 0.

## Timing
- Reset values: cpu_ack=0, cpu_rdata=0, stall_max=0, WB empty, FSM in IDLE, mem_we=0, mem_addr=0 while vid_req=0.
- Reset mid-operation discards the WB and any pending read, and no ack is issued. The CPU must re-request.
- Write with WB empty: ack arrives 1 cycle after the accept cycle, i.e. the 2nd edge after req is seen. The RAM write happens later, at the first cycle with vid_req=0.
- Read with no video contention: accept at t, issue at t+1, capture at t+2, ack high during t+3.
- Each cycle of vid_req=1 while in RD_WAIT, or while WB is full ahead of the read, adds exactly 1 cycle.
- Continuous vid_req=1 starves the CPU indefinitely. This is legal; stall_max records it.
- A write in the same cycle as a WB drain cannot occur: accept requires WB empty at the clock edge.

## Structure
- Shared package vram_pkg holds:
  - FSM state enum (IDLE, RD_WAIT, RD_DATA, ACK).
  - Default AW and SW constants.
  - Scanout base constant VRAM_GFX_BASE = 18'h30000, used by the scanout and CPU decode.
- One sub-module, vram_stall_mon, holds wait_cnt, stall_max, saturation and clear.
- The slot mux and FSM stay in the top module.

## Test plan
- Idle bus, CPU write 0x5A to 0x00010, then a read of 0x00011 (which holds 0x33): the write acks 2 cycles after req; mem_we pulses with addr 0x00010. The read acks in the 4th cycle with cpu_rdata=0x33.
- WB full on 0x00100=0x77, with vid_req held high to block the drain, then a read of 0x00100: ack with cpu_rdata=0x77 and no mem_we=0 read issued for that address.
- Write to 0x200=0x11, then an immediate read of 0x200 with vid_req pulsed 3 cycles: the forwarded value is 0x11. With vid_req released, the RAM at 0x200 becomes 0x11.
- Text-mode pattern with vid_req high on phases 0–3 of every 8: no scanout cycle is ever diverted, vid_rdata matches the RAM model, and CPU reads complete within ≤ 7 cycles.
- vid_req held high for 70000 cycles with a CPU read pending: stall_max saturates at 0xFFFF. stall_clr then zeroes it. After vid_req drops, the read completes.
- reset_n asserted during RD_WAIT and with WB full: outputs return to reset values at once, no ack occurs, and the buffered write is never written.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
// Scanout and CPU decode both use the graphics base.
package vram_pkg;

    localparam int VRAM_AW = 18;
    localparam int VRAM_SW = 16;

    localparam logic [17:0] VRAM_GFX_BASE = 18'h30000;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        ACK
    } cpu_st_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU request/acknowledge bus into the VRAM arbiter.
// master = CPU side, slave = arbiter side.
interface vram_arbiter_if #(
    parameter int AW = 18
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;

    modport master (
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_ack,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_ack,
        output cpu_rdata
    );
endinterface

// File: rtl/vram_arbiter_stall_mon.sv
// Tracks the current CPU wait and the worst wait seen.
// Both counters saturate; clear beats a coinciding update.
module vram_stall_mon #(
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req_i,
    input  logic          in_ack_i,
    input  logic          clr_i,
    output logic [SW-1:0] stall_max_o
);

    logic [SW-1:0] wait_q, wait_d;
    logic [SW-1:0] max_q, max_d;

    always_comb begin
        wait_d = wait_q;
        max_d  = max_q;
        if (in_ack_i) begin
            wait_d = '0;
        end else if (cpu_req_i && (wait_q != '1)) begin
            wait_d = wait_q + SW'(1);
        end
        if (clr_i) begin
            max_d = '0;
        end else if (wait_q > max_q) begin
            max_d = wait_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            max_q  <= '0;
        end else begin
            wait_q <= wait_d;
            max_q  <= max_d;
        end
    end

    assign stall_max_o = max_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout has absolute priority, the CPU
// uses free slots via a posted write buffer and a small read FSM.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int SW = VRAM_SW
) (
    input  logic          clock_25,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_rdata,
    vram_arbiter_if.slave cpu,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          stall_clr,
    output logic [SW-1:0] stall_max
);

    cpu_st_e       state_q, state_d;
    logic          wb_full_q, wb_full_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic [7:0]    wb_data_q, wb_data_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [AW-1:0] last_addr_q;
    logic          drain;
    logic          issue;

    // Slot mux: combinational so scanout timing is untouched.
    always_comb begin
        mem_addr  = last_addr_q;
        mem_we    = 1'b0;
        mem_wdata = wb_data_q;
        drain     = 1'b0;
        issue     = 1'b0;
        if (vid_req) begin
            mem_addr = vid_addr;
        end else if (wb_full_q) begin
            mem_addr = wb_addr_q;
            mem_we   = 1'b1;
            drain    = 1'b1;
        end else if (state_q == RD_WAIT) begin
            mem_addr = rd_addr_q;
            issue    = 1'b1;
        end
    end

    assign vid_rdata = mem_rdata;

    always_comb begin
        state_d   = state_q;
        wb_full_d = wb_full_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        if (drain) begin
            wb_full_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (cpu.cpu_req) begin
                    if (cpu.cpu_we) begin
                        if (!wb_full_q) begin
                            wb_full_d = 1'b1;
                            wb_addr_d = cpu.cpu_addr;
                            wb_data_d = cpu.cpu_wdata;
                            state_d   = ACK;
                        end
                    end else if (wb_full_q &&
                                 (wb_addr_q == cpu.cpu_addr)) begin
                        // Read hits the posted write: no RAM access.
                        rdata_d = wb_data_q;
                        state_d = ACK;
                    end else begin
                        rd_addr_d = cpu.cpu_addr;
                        state_d   = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (issue) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                rdata_d = mem_rdata;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wb_full_q   <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            rd_addr_q   <= '0;
            rdata_q     <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            wb_full_q   <= wb_full_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            rd_addr_q   <= rd_addr_d;
            rdata_q     <= rdata_d;
            last_addr_q <= mem_addr;
        end
    end

    assign cpu.cpu_ack   = (state_q == ACK);
    assign cpu.cpu_rdata = rdata_q;

    vram_stall_mon #(
        .SW(SW)
    ) u_stall (
        .clk        (clock_25),
        .rst_n      (reset_n),
        .cpu_req_i  (cpu.cpu_req),
        .in_ack_i   (state_q == ACK),
        .clr_i      (stall_clr),
        .stall_max_o(stall_max)
    );

endmodule
